// File: rtl/dict_pkg.sv
// Shared types for the dictionary request scheduler.
// Command/response encodings, FSM states and the request bundle.
package dict_pkg;

  localparam int DICT_DATA_W = 80;
  localparam int DICT_IDX_W  = 8;
  localparam int DICT_TAG_W  = 4;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_COMP   = 2'b01,
    CMD_DECOMP = 2'b10,
    CMD_BAD    = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    RSP_COMP_OK   = 2'b01,
    RSP_DECOMP_OK = 2'b10,
    RSP_ERR       = 2'b11
  } rsp_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_HOLD
  } sched_state_e;

  typedef struct packed {
    cmd_e                   cmd;
    logic [DICT_DATA_W-1:0] data;
    logic [DICT_IDX_W-1:0]  idx;
    logic [DICT_TAG_W-1:0]  tag;
  } req_t;

  function automatic logic cmd_legal(input logic [1:0] c);
    return (c == CMD_COMP) || (c == CMD_DECOMP);
  endfunction

endpackage

// File: rtl/dict_req_fifo.sv
// Synchronous request FIFO, power-of-two depth.
// Head entry is read combinationally; no write-to-read bypass.
module dict_req_fifo
  import dict_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = req_t
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  entry_t                   wdata,
  input  logic                     pop,
  output entry_t                   rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dict_req_scheduler.sv
// Request scheduler in front of the dictionary engine: FIFO, one-at-a-time issue, held response.
// Optional DICT_REQ_STATS_EN adds saturating per-code response counters.
module dict_req_scheduler
  import dict_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = DICT_DATA_W,
  parameter int IDX_W      = DICT_IDX_W,
  parameter int TAG_W      = DICT_TAG_W
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_cmd,
  input  logic [DATA_W-1:0]             req_data,
  input  logic [IDX_W-1:0]              req_idx,
  input  logic [TAG_W-1:0]              req_tag,
  output logic [1:0]                    eng_command,
  output logic [DATA_W-1:0]             eng_data_in,
  output logic [IDX_W-1:0]              eng_compressed_in,
  input  logic [IDX_W-1:0]              eng_compressed_out,
  input  logic [DATA_W-1:0]             eng_decompressed_out,
  input  logic [1:0]                    eng_response,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [1:0]                    rsp_code,
  output logic [IDX_W-1:0]              rsp_idx,
  output logic [DATA_W-1:0]             rsp_data,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef DICT_REQ_STATS_EN
  ,
  output logic [15:0]                   stat_comp,
  output logic [15:0]                   stat_decomp,
  output logic [15:0]                   stat_err
`endif
);

  typedef struct packed {
    logic [1:0]        cmd;
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t       wr_entry;
  entry_t       head;
  logic         full;
  logic         empty;
  logic         pop;
  logic         load;
  logic         capture;
  logic         ack;
  sched_state_e state;
  sched_state_e state_n;

  logic [1:0]        cur_cmd;
  logic [DATA_W-1:0] cur_data;
  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]  cur_tag;

  assign wr_entry = '{cmd: req_cmd, data: req_data,
                      idx: req_idx, tag: req_tag};
  assign req_ready = !full;

  dict_req_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (req_valid),
    .wdata   (wr_entry),
    .pop     (pop),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    load    = 1'b0;
    capture = 1'b0;
    ack     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_n = cmd_legal(head.cmd) ? S_ISSUE : S_HOLD;
        end
      end
      S_ISSUE: state_n = S_CAPTURE;
      S_CAPTURE: begin
        capture = 1'b1;
        state_n = S_HOLD;
      end
      S_HOLD: begin
        if (rsp_ready) begin
          ack = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            load    = 1'b1;
            state_n = cmd_legal(head.cmd) ? S_ISSUE : S_HOLD;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign eng_command       = (state == S_ISSUE) ? cur_cmd : CMD_NOP;
  assign eng_data_in       = cur_data;
  assign eng_compressed_in = cur_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_cmd   <= CMD_NOP;
      cur_data  <= '0;
      cur_idx   <= '0;
      cur_tag   <= '0;
      rsp_valid <= 1'b0;
      rsp_code  <= 2'b00;
      rsp_idx   <= '0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
    end else begin
      if (load) begin
        cur_cmd  <= head.cmd;
        cur_data <= head.data;
        cur_idx  <= head.idx;
        cur_tag  <= head.tag;
      end
      if (ack) rsp_valid <= 1'b0;
      // Illegal commands never reach the engine; answer straight away.
      if (load && !cmd_legal(head.cmd)) begin
        rsp_valid <= 1'b1;
        rsp_code  <= RSP_ERR;
        rsp_idx   <= '0;
        rsp_data  <= '0;
        rsp_tag   <= head.tag;
      end
      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_code  <= eng_response;
        rsp_tag   <= cur_tag;
        if (cur_cmd == CMD_COMP) begin
          rsp_idx  <= eng_compressed_out;
          rsp_data <= '0;
        end else begin
          rsp_idx  <= cur_idx;
          rsp_data <= eng_decompressed_out;
        end
      end
    end
  end

`ifdef DICT_REQ_STATS_EN
  logic hs;
  assign hs = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_comp   <= '0;
      stat_decomp <= '0;
      stat_err    <= '0;
    end else if (hs) begin
      if (rsp_code == RSP_COMP_OK && stat_comp != 16'hFFFF)
        stat_comp <= stat_comp + 16'd1;
      if (rsp_code == RSP_DECOMP_OK && stat_decomp != 16'hFFFF)
        stat_decomp <= stat_decomp + 16'd1;
      if (rsp_code == RSP_ERR && stat_err != 16'hFFFF)
        stat_err <= stat_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dict_req_scheduler.sv
// Directed bench for dict_req_scheduler with a small behavioural dictionary engine.
// The engine holds 16 words and is reset once at start only.
module tb_dict_req_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        eng_rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cmd;
  logic [79:0] req_data;
  logic [7:0]  req_idx;
  logic [3:0]  req_tag;
  logic [1:0]  eng_command;
  logic [79:0] eng_data_in;
  logic [7:0]  eng_compressed_in;
  logic [7:0]  eng_compressed_out;
  logic [79:0] eng_decompressed_out;
  logic [1:0]  eng_response;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_code;
  logic [7:0]  rsp_idx;
  logic [79:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic [2:0]  fifo_count;
`ifdef DICT_REQ_STATS_EN
  logic [15:0] stat_comp;
  logic [15:0] stat_decomp;
  logic [15:0] stat_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dict_req_scheduler dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_cmd              (req_cmd),
    .req_data             (req_data),
    .req_idx              (req_idx),
    .req_tag              (req_tag),
    .eng_command          (eng_command),
    .eng_data_in          (eng_data_in),
    .eng_compressed_in    (eng_compressed_in),
    .eng_compressed_out   (eng_compressed_out),
    .eng_decompressed_out (eng_decompressed_out),
    .eng_response         (eng_response),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_code             (rsp_code),
    .rsp_idx              (rsp_idx),
    .rsp_data             (rsp_data),
    .rsp_tag              (rsp_tag),
    .fifo_count           (fifo_count)
`ifdef DICT_REQ_STATS_EN
    ,
    .stat_comp            (stat_comp),
    .stat_decomp          (stat_decomp),
    .stat_err             (stat_err)
`endif
  );

  logic [79:0] dict [16];
  logic [4:0]  dict_n;
  logic        hit;
  logic [7:0]  hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < 16; k++) begin
      if (!hit && 5'(k) < dict_n && dict[k] == eng_data_in) begin
        hit     = 1'b1;
        hit_idx = 8'(k);
      end
    end
  end

  // Engine registers its results; a NOP cycle reports 11.
  always @(posedge clk) begin
    if (!eng_rst_n) begin
      dict_n               <= '0;
      eng_response         <= 2'b00;
      eng_compressed_out   <= '0;
      eng_decompressed_out <= '0;
    end else begin
      case (eng_command)
        2'b01: begin
          if (hit) begin
            eng_compressed_out <= hit_idx;
            eng_response       <= 2'b01;
          end else if (dict_n < 5'd16) begin
            dict[dict_n[3:0]]  <= eng_data_in;
            eng_compressed_out <= 8'(dict_n);
            dict_n             <= dict_n + 5'd1;
            eng_response       <= 2'b01;
          end else begin
            eng_response <= 2'b11;
          end
        end
        2'b10: begin
          if (eng_compressed_in < 8'(dict_n)) begin
            eng_decompressed_out <= dict[eng_compressed_in[3:0]];
            eng_response         <= 2'b10;
          end else begin
            eng_response <= 2'b11;
          end
        end
        default: eng_response <= 2'b11;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] obs,
                       input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] c, input logic [79:0] d,
                      input logic [7:0] i, input logic [3:0] t);
    int w;
    w = 0;
    req_cmd   = c;
    req_data  = d;
    req_idx   = i;
    req_tag   = t;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) check("push_timeout", 80'(w), 80'd0);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int lim, output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    if (n >= lim) check("rsp_timeout", 80'(n), 80'(lim - 1));
  endtask

  logic [3:0]  e_tag  [5] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
  logic [1:0]  e_code [5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
  logic [7:0]  e_idx  [5] = '{8'd0, 8'd3, 8'd0, 8'd3, 8'd2};
  logic [79:0] e_data [5] = '{80'h0, 80'h0, 80'h1234, 80'hC, 80'h0};

  initial begin
    int n;
    reset_n   = 1'b0;
    eng_rst_n = 1'b0;
    req_valid = 1'b0;
    req_cmd   = 2'b00;
    req_data  = '0;
    req_idx   = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    check("rst_rsp_valid", 80'(rsp_valid), 80'd0);
    check("rst_fifo_count", 80'(fifo_count), 80'd0);
    check("rst_req_ready", 80'(req_ready), 80'd1);
    check("rst_eng_command", 80'(eng_command), 80'd0);
    check("rst_eng_data_in", eng_data_in, 80'd0);
    check("rst_eng_comp_in", 80'(eng_compressed_in), 80'd0);
    check("rst_rsp_code", 80'(rsp_code), 80'd0);
    check("rst_rsp_tag", 80'(rsp_tag), 80'd0);
    reset_n   = 1'b1;
    eng_rst_n = 1'b1;
    tick();

    push(2'b01, 80'h1234, 8'd0, 4'd3);
    check("t1_count", 80'(fifo_count), 80'd1);
    check("t1_cmd_idle", 80'(eng_command), 80'd0);
    tick();
    check("t1_cmd_issue", 80'(eng_command), 80'd1);
    check("t1_data_in", eng_data_in, 80'h1234);
    tick();
    check("t1_cmd_capture", 80'(eng_command), 80'd0);
    check("t1_valid_early", 80'(rsp_valid), 80'd0);
    tick();
    check("t1_valid", 80'(rsp_valid), 80'd1);
    check("t1_code", 80'(rsp_code), 80'd1);
    check("t1_idx", 80'(rsp_idx), 80'd0);
    check("t1_tag", 80'(rsp_tag), 80'd3);
    check("t1_data", rsp_data, 80'd0);
    tick();
    check("t1_valid_drop", 80'(rsp_valid), 80'd0);

    // 1234 already holds index 0, so A and B land at 1 and 2.
    push(2'b01, 80'hA, 8'd0, 4'd1);
    check("t2_ready0", 80'(req_ready), 80'd1);
    push(2'b01, 80'hB, 8'd0, 4'd2);
    check("t2_ready1", 80'(req_ready), 80'd1);
    push(2'b01, 80'hA, 8'd0, 4'd4);
    check("t2_count", 80'(fifo_count), 80'd2);
    check("t2_ready2", 80'(req_ready), 80'd1);
    wait_rsp(10, n);
    check("t2_lat0", 80'(n), 80'd1);
    check("t2_idx0", 80'(rsp_idx), 80'd1);
    check("t2_tag0", 80'(rsp_tag), 80'd1);
    tick();
    wait_rsp(10, n);
    check("t2_gap1", 80'(n), 80'd2);
    check("t2_idx1", 80'(rsp_idx), 80'd2);
    check("t2_tag1", 80'(rsp_tag), 80'd2);
    tick();
    wait_rsp(10, n);
    check("t2_gap2", 80'(n), 80'd2);
    check("t2_idx2", 80'(rsp_idx), 80'd1);
    check("t2_tag2", 80'(rsp_tag), 80'd4);
    tick();

    push(2'b10, 80'h0, 8'd2, 4'd5);
    wait_rsp(10, n);
    check("t3_lat", 80'(n), 80'd3);
    check("t3_code", 80'(rsp_code), 80'd2);
    check("t3_data", rsp_data, 80'hB);
    check("t3_idx", 80'(rsp_idx), 80'd2);
    check("t3_tag", 80'(rsp_tag), 80'd5);
    tick();
    push(2'b10, 80'h0, 8'd200, 4'd6);
    wait_rsp(10, n);
    check("t3_oor_code", 80'(rsp_code), 80'd3);
    check("t3_oor_idx", 80'(rsp_idx), 80'd200);
    check("t3_oor_tag", 80'(rsp_tag), 80'd6);
    tick();

    push(2'b11, 80'h5, 8'd9, 4'd7);
    check("t4_cmd0", 80'(eng_command), 80'd0);
    tick();
    check("t4_valid", 80'(rsp_valid), 80'd1);
    check("t4_code", 80'(rsp_code), 80'd3);
    check("t4_tag", 80'(rsp_tag), 80'd7);
    check("t4_idx", 80'(rsp_idx), 80'd0);
    check("t4_data", rsp_data, 80'd0);
    check("t4_cmd1", 80'(eng_command), 80'd0);
    tick();
    check("t4_cmd2", 80'(eng_command), 80'd0);
    check("t4_valid_drop", 80'(rsp_valid), 80'd0);

    rsp_ready = 1'b0;
    push(2'b01, 80'h1234, 8'd0, 4'd8);
    push(2'b01, 80'hC, 8'd0, 4'd9);
    push(2'b10, 80'h0, 8'd0, 4'd10);
    push(2'b10, 80'h0, 8'd3, 4'd11);
    push(2'b01, 80'hB, 8'd0, 4'd12);
    tick();
    tick();
    check("t5_ready", 80'(req_ready), 80'd0);
    check("t5_count", 80'(fifo_count), 80'd4);
    check("t5_valid", 80'(rsp_valid), 80'd1);
    check("t5_hold_tag", 80'(rsp_tag), 80'd8);
    tick();
    tick();
    check("t5_stable_valid", 80'(rsp_valid), 80'd1);
    check("t5_stable_tag", 80'(rsp_tag), 80'd8);
    check("t5_stable_code", 80'(rsp_code), 80'd1);
    check("t5_stable_idx", 80'(rsp_idx), 80'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(10, n);
      check($sformatf("t5_tag%0d", i), 80'(rsp_tag), 80'(e_tag[i]));
      check($sformatf("t5_code%0d", i), 80'(rsp_code), 80'(e_code[i]));
      check($sformatf("t5_idx%0d", i), 80'(rsp_idx), 80'(e_idx[i]));
      check($sformatf("t5_data%0d", i), rsp_data, e_data[i]);
      tick();
    end
    check("t5_drain", 80'(fifo_count), 80'd0);

    push(2'b01, 80'hA, 8'd0, 4'd1);
    push(2'b01, 80'hB, 8'd0, 4'd2);
    push(2'b01, 80'hC, 8'd0, 4'd3);
    check("t6_count_pre", 80'(fifo_count), 80'd2);
    check("t6_capture_cmd", 80'(eng_command), 80'd0);
    reset_n = 1'b0;
    #1;
    check("t6_valid", 80'(rsp_valid), 80'd0);
    check("t6_count", 80'(fifo_count), 80'd0);
    check("t6_cmd", 80'(eng_command), 80'd0);
    check("t6_ready", 80'(req_ready), 80'd1);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t6_quiet_valid%0d", i), 80'(rsp_valid), 80'd0);
      check($sformatf("t6_quiet_cmd%0d", i), 80'(eng_command), 80'd0);
    end
    push(2'b01, 80'hA, 8'd0, 4'd9);
    wait_rsp(10, n);
    check("t6_post_lat", 80'(n), 80'd3);
    check("t6_post_idx", 80'(rsp_idx), 80'd1);
    check("t6_post_tag", 80'(rsp_tag), 80'd9);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
